pes_debounce_edge: RTL and testbench
====================================

# pes_debounce_edge

Input conditioning stage that sits directly upstream of the async-reset D flip-flop cell. It takes a raw, asynchronous, possibly bouncing external signal and brings it into the `clk` domain with a two-flop synchronizer. A counter-based state machine then debounces it. The clean level drives the downstream flop's data input, and single-cycle rise/fall pulses plus a glitch statistic are provided for other logic.

## Interface
- `STABLE_CYCLES`, default 1000: consecutive synchronized cycles the new value must hold before it is accepted. Legal range is 2 to 2^20.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high. It is sampled on the rising edge of `clk` and overrides all other activity.
- `i_raw` input 1: asynchronous raw input (pad/button); no timing relationship to `clk`.
- `o_level` output 1: debounced level, registered; feeds the downstream flop's `i_d`.
- `o_rise` output 1: one-cycle pulse when `o_level` goes 0→1.
- `o_fall` output 1: one-cycle pulse when `o_level` goes 1→0.
- `o_busy` output 1: high while a candidate transition is being qualified (WAIT states).
- `o_glitch_cnt` output 8: number of aborted qualifications, saturating at 255.

## Operation
- Synchronizer: `sync1 <= i_raw`, `sync2 <= sync1` every cycle. Only `sync2` (called `s`) is used downstream. No logic between the two flops.
- Counter width is `$clog2(STABLE_CYCLES+1)` bits.
- States:
  - IDLE_LOW: `o_level`=0, counter 0. If `s`=1, go to WAIT_HIGH with counter←1.
  - WAIT_HIGH: if `s`=1 and counter=STABLE_CYCLES-1, go to IDLE_HIGH, `o_level`←1, `o_rise`←1, counter←0. If `s`=1 otherwise, counter+1. If `s`=0, abort: back to IDLE_LOW, counter←0, glitch count +1.
  - IDLE_HIGH: `o_level`=1, counter 0. If `s`=0, go to WAIT_LOW with counter←1.
  - WAIT_LOW: mirror of WAIT_HIGH; on commit `o_level`←0 and `o_fall`←1, go to IDLE_LOW.
- `o_busy` = 1 exactly in WAIT_HIGH/WAIT_LOW. It is registered as a state decode with no combinational path from `i_raw`.
- `o_rise`/`o_fall` are registered. Each is high for exactly one cycle, coincident with the first cycle `o_level` shows the new value. They are never both high.
- `o_glitch_cnt` increments by 1 on each abort edge and holds at 255. It is cleared only by `reset`.
- Unused state encodings return to IDLE_LOW with `o_level`=0 on the next edge.

## Timing
- Reset values, applied at the edge where `reset`=1: `sync1`=0, `sync2`=0, state IDLE_LOW, counter 0, `o_level`=0, `o_rise`=0, `o_fall`=0, `o_busy`=0, `o_glitch_cnt`=0.
- Reset mid-qualification abandons the candidate. No pulse is emitted and the glitch count is not incremented.
- Latency: count edge 1 as the first rising edge that samples the new `i_raw` into `sync1`. `o_level` changes on edge STABLE_CYCLES+2, provided `i_raw` holds stable throughout. Example: STABLE_CYCLES=4 gives edge 6.
- A bounce visible in `s` for even one cycle during WAIT aborts qualification and restarts it. Timing restarts from the next edge where `s` differs from `o_level`.
- If `i_raw` is held at 1 through reset release, `o_level` rises at edge STABLE_CYCLES+2 after the first edge with `reset`=0. `o_rise` pulses at that same edge.
- Continuous bouncing never commits and never lets the counter overflow; counter ≤ STABLE_CYCLES-1 always.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset: hold `reset`=1 for 3 cycles with `i_raw`=X/1 → all outputs 0; `o_glitch_cnt`=0.
- Clean rise: `i_raw` 0→1, held. `o_level`=1 from edge 6 (counting the first sampling edge as 1). `o_rise`=1 for that one cycle only. `o_busy`=1 on edges 3–5 and 0 afterwards.
- Bounce: `i_raw` goes 1 for 3 cycles, 0 for 1 cycle, then 1 held. `o_level` stays 0 until 4 clean cycles of `s`=1 plus sync latency. `o_glitch_cnt`=1. `o_rise` pulses exactly once.
- Clean fall after rise: `i_raw` 1→0 held → `o_level`=0 six edges later, one `o_fall` pulse, `o_rise` stays 0.
- Glitch saturation: 300 alternating 2-cycle-high/2-cycle-low bursts → `o_level` never changes. `o_glitch_cnt`=255 and holds there.
- Reset mid-qualification: assert `reset` while `o_busy`=1 → next cycle state IDLE_LOW, `o_busy`=0, no `o_rise`, `o_glitch_cnt` unchanged at 0.

Source files
------------

// File: rtl/pes_debounce_edge.sv
// pes_debounce_edge
//
// Input conditioning for a raw asynchronous signal (pad/button). The raw input
// is brought into the clk domain through a two-flop synchronizer, then a
// counter-based state machine debounces it: a new level is accepted only after
// the synchronized value has held for STABLE_CYCLES consecutive cycles.
//
// Ports:
//   clk          - single clock, all state updates on its rising edge
//   reset        - synchronous, active-high, overrides all other activity
//   i_raw        - asynchronous raw input, no timing relationship to clk
//   o_level      - registered debounced level (feeds a downstream flop's data input)
//   o_rise       - one-cycle pulse, first cycle o_level shows 1 after being 0
//   o_fall       - one-cycle pulse, first cycle o_level shows 0 after being 1
//   o_busy       - high while a candidate transition is being qualified
//   o_glitch_cnt - count of aborted qualifications, saturating at 255
//
// Parameter:
//   STABLE_CYCLES - cycles a new value must hold before acceptance (2 .. 2^20)

module pes_debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_raw,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_busy,
    output logic [7:0] o_glitch_cnt
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdleLow  = 2'b00,
        StWaitHigh = 2'b01,
        StIdleHigh = 2'b10,
        StWaitLow  = 2'b11
    } state_e;

    // Synchronizer flops; nothing sits between them.
    logic sync1_q;
    logic sync2_q;
    logic s;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            busy_q, busy_d;
    logic [7:0]      glitch_q, glitch_d;
    logic            abort;

    assign s = sync2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        abort    = 1'b0;

        case (state_q)
            StIdleLow: begin
                level_d = 1'b0;
                cnt_d   = '0;
                if (s) begin
                    state_d = StWaitHigh;
                    cnt_d   = CntOne;
                end
            end
            StWaitHigh: begin
                if (s) begin
                    if (cnt_q == CntLast) begin
                        state_d = StIdleHigh;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    state_d = StIdleLow;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end
            end
            StIdleHigh: begin
                level_d = 1'b1;
                cnt_d   = '0;
                if (!s) begin
                    state_d = StWaitLow;
                    cnt_d   = CntOne;
                end
            end
            StWaitLow: begin
                if (!s) begin
                    if (cnt_q == CntLast) begin
                        state_d = StIdleLow;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end else begin
                    state_d = StIdleHigh;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end
            end
            default: begin
                state_d = StIdleLow;
                level_d = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Busy is decoded from the next state so the registered flag lines up
        // with the state register.
        busy_d = (state_d == StWaitHigh) || (state_d == StWaitLow);

        glitch_d = glitch_q;
        if (abort && (glitch_q != 8'hff)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= StIdleLow;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= 8'd0;
        end else begin
            sync1_q  <= i_raw;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign o_level      = level_q;
    assign o_rise       = rise_q;
    assign o_fall       = fall_q;
    assign o_busy       = busy_q;
    assign o_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_pes_debounce_edge.sv
// Testbench for pes_debounce_edge with STABLE_CYCLES=4. Directed scenarios plus
// randomized bursts, every cycle compared against a behavioural model that
// tracks how long the synchronized input has disagreed with the accepted level.

module tb_pes_debounce_edge;

    localparam int unsigned Stable = 4;

    logic       clk;
    logic       reset;
    logic       i_raw;
    logic       o_level;
    logic       o_rise;
    logic       o_fall;
    logic       o_busy;
    logic [7:0] o_glitch_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    bit m_s1, m_s2;
    bit m_level, m_rise, m_fall;
    int m_run;
    int m_glitch;

    pes_debounce_edge #(
        .STABLE_CYCLES(Stable)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_raw       (i_raw),
        .o_level     (o_level),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_busy      (o_busy),
        .o_glitch_cnt(o_glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Model of one rising edge: the synchronizer delays by two edges, and a
    // new level is accepted once the delayed input has differed from the
    // current level for Stable edges in a row. Any agreement in between is
    // a glitch.
    task automatic model_edge(input logic raw_v, input logic rst_v);
        bit s;
        if (rst_v) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_glitch = 0;
        end else begin
            s      = m_s2;
            m_s2   = m_s1;
            m_s1   = (raw_v === 1'b1);
            m_rise = 0;
            m_fall = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == Stable) begin
                    m_level = s;
                    m_rise  = s;
                    m_fall  = !s;
                    m_run   = 0;
                end
            end else if (m_run > 0) begin
                if (m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
    endtask

    task automatic check_all();
        check("level", int'(o_level), int'(m_level));
        check("rise", int'(o_rise), int'(m_rise));
        check("fall", int'(o_fall), int'(m_fall));
        check("busy", int'(o_busy), int'(m_run > 0));
        check("glitch_cnt", int'(o_glitch_cnt), m_glitch);
        check("rise_fall_excl", int'(o_rise & o_fall), 0);
    endtask

    task automatic step(input logic raw_v, input logic rst_v);
        i_raw = raw_v;
        reset = rst_v;
        @(posedge clk);
        model_edge(raw_v, rst_v);
        #1;
        check_all();
    endtask

    initial begin
        int first;
        int rises;
        int falls;
        bit moved;
        logic v;

        i_raw = 1'bx;
        reset = 1'b1;
        #2;

        // Reset with unknown then high raw input.
        step(1'bx, 1'b1);
        step(1'bx, 1'b1);
        step(1'b1, 1'b1);
        check("reset_level", int'(o_level), 0);
        check("reset_glitch", int'(o_glitch_cnt), 0);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Clean rise: level must appear on edge Stable+2.
        first = 0; rises = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            if (o_level && first == 0) first = e;
            if (o_rise) rises++;
        end
        check("rise_edge", first, Stable + 2);
        check("rise_pulses", rises, 1);

        // Clean fall.
        first = 0; falls = 0; rises = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b0);
            if (!o_level && first == 0) first = e;
            if (o_fall) falls++;
            if (o_rise) rises++;
        end
        check("fall_edge", first, Stable + 2);
        check("fall_pulses", falls, 1);
        check("fall_no_rise", rises, 0);

        // Bounce: 1 x3, 0 x1, then 1 held.
        rises = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            if (o_rise) rises++;
        end
        check("bounce_glitch", int'(o_glitch_cnt), 1);
        check("bounce_rise_once", rises, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Randomized segments of random length.
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            v   = logic'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) step(v, 1'b0);
        end

        // Glitch saturation from a clean low level.
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        moved = 0;
        for (int b = 0; b < 300; b++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            if (o_level) moved = 1;
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("sat_level_moved", int'(moved), 0);
        check("sat_glitch", int'(o_glitch_cnt), 255);

        // Reset mid-qualification.
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("midq_busy", int'(o_busy), 1);
        step(1'b1, 1'b1);
        check("midq_busy_cleared", int'(o_busy), 0);
        check("midq_no_rise", int'(o_rise), 0);
        check("midq_glitch", int'(o_glitch_cnt), 0);

        // Raw held high through reset release.
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            if (o_level && first == 0) begin
                first = e;
                check("hold_rise_pulse", int'(o_rise), 1);
            end
        end
        check("hold_rise_edge", first, Stable + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
